rp_chs_calc: RTL and testbench
==============================

RP_CHS_CALC -- requirements
Module: rp_chs_calc

Interface
REQ-001 clk  input  1  Clock; all state changes occur on its rising edge.
REQ-002 rst  input  1  Reset; asynchronous and active-high.
REQ-003 rpTRKNUM  input  6  Number of tracks per cylinder; sampled at start.
REQ-004 rpSECNUM  input  6  Number of sectors per track; sampled at start.
REQ-005 rpSDLSA  input  21  SD linear sector address to decode; sampled at start.
REQ-006 rpCHSSTRT  input  1  Start-conversion strobe.
REQ-007 rpCHSBUSY  output  1  High while a conversion is in progress.
REQ-008 rpDCA  output  10  Decoded cylinder.
REQ-009 rpTA  output  6  Decoded track.
REQ-010 rpSA  output  6  Decoded sector.
REQ-011 rpCHSERR  output  1  Conversion error flag; see REQ-026.

Function
REQ-012 The block SHALL invert the SIMH address mapping, in which LSA = ((DCA*TRKNUM + TA)*SECNUM + SA)*2.
- The block SHALL compute H = LSA[20:1], a 20-bit value.
- SA SHALL be H mod SECNUM, and Q = H div SECNUM.
- TA SHALL be Q mod TRKNUM, and DCA = Q div TRKNUM, truncated to 10 bits.
REQ-013 The block SHALL be a state machine with the states IDLE, LOAD, SECT and TRACK.
REQ-014 In IDLE, when rpCHSSTRT=1, the block SHALL latch rpSDLSA, rpTRKNUM and rpSECNUM, then go to LOAD.
REQ-015 LOAD (1 cycle) SHALL form H and clear the partial remainder, then go to SECT.
REQ-016 SECT SHALL perform a 20-cycle restoring division of H by SECNUM (one quotient bit per cycle, MSB first), then go to TRACK.
REQ-017 TRACK SHALL perform a 20-cycle restoring division of Q by TRKNUM, then return to IDLE.
REQ-018 rpCHSBUSY SHALL equal (state != IDLE), so it is high for exactly 41 cycles per conversion.
REQ-019 rpDCA, rpTA, rpSA and rpCHSERR SHALL update only on the clock edge that returns the state machine to IDLE.
- They SHALL hold their values until the next conversion completes.
REQ-020 rpCHSSTRT SHALL be ignored while busy; a start in the completion cycle is not captured.
REQ-021 Input changes after start SHALL NOT affect the running conversion.
REQ-022 A zero SECNUM or TRKNUM SHALL yield rpDCA=0, rpTA=0 and rpSA=0.
REQ-023 Remainders SHALL fit in 6 bits; intermediate quotients are 20 bits wide.

Reset
REQ-024 rst SHALL asynchronously force state=IDLE, rpCHSBUSY=0, rpDCA=0, rpTA=0, rpSA=0 and rpCHSERR=0.
REQ-025 Reset mid-conversion SHALL abort the conversion with no output update; the next start SHALL run normally.

Configuration
REQ-026 With macro RPCHS_RANGECHK_EN defined, rpCHSERR SHALL be set at completion if any of the following holds:
- LSA[0]=1;
- SECNUM=0 or TRKNUM=0;
- Q div TRKNUM > 1023.
rpCHSERR SHALL be cleared at the completion of an error-free conversion.
REQ-027 Without RPCHS_RANGECHK_EN, rpCHSERR SHALL be tied to 0, LSA[0] SHALL be ignored, and DCA SHALL be silently truncated to 10 bits.

Structure
REQ-028 A shared package SHALL hold the state encoding constants and width constants: LSA=21, DCA=10, TA/SA=6, H=20.
REQ-029 One sub-module, rp_seqdiv, SHALL be instantiated once and reused for both divisions.
- rp_seqdiv SHALL be a 20-bit by 6-bit restoring divider with start/done signalling.

Verification
REQ-030 Scenario: TRKNUM=19, SECNUM=20, LSA=3934, start -> busy for 41 cycles; then DCA=5, TA=3, SA=7, ERR=0.
REQ-031 Scenario: TRKNUM=19, SECNUM=20, LSA=778238 -> DCA=1023, TA=18, SA=19, ERR=0; LSA=0 -> 0/0/0, ERR=0.
REQ-032 Scenario: LSA=3935 -> with the macro: 5/3/7 and ERR=1; without the macro: 5/3/7 and ERR=0.
REQ-033 Scenario: TRKNUM=1, SECNUM=1, LSA=2048 -> with the macro: ERR=1 and DCA=0 (truncated); SECNUM=0 -> outputs 0, ERR=1 with the macro.
REQ-034 Scenario: start pulse at cycle 10 of a busy period with new inputs -> ignored, and the first result is unchanged.
REQ-035 Scenario: rst asserted at cycle 20 of a conversion -> busy=0 immediately and all outputs 0; a following start with LSA=3934 -> 5/3/7.

Source files
------------

// File: rtl/rp_chs_calc_pkg.sv
// Shared constants and state encoding for the RP linear-sector to cylinder/track/sector decoder.
package rp_chs_calc_pkg;

  localparam int unsigned LsaW     = 21;
  localparam int unsigned HW       = 20;
  localparam int unsigned DcaW     = 10;
  localparam int unsigned TsW      = 6;
  localparam int unsigned DivSteps = 20;
  localparam int unsigned CntW     = 5;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StSect,
    StTrack
  } chs_state_e;

endpackage

// File: rtl/rp_seqdiv.sv
// Sequential 20-bit by 6-bit restoring divider, one quotient bit per cycle, MSB first.
// done_o marks the final step; quotient_o/remainder_o carry that step's result in the same cycle.
module rp_seqdiv
  import rp_chs_calc_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic [HW-1:0]  dividend_i,
  input  logic [TsW-1:0] divisor_i,
  output logic           done_o,
  output logic [HW-1:0]  quotient_o,
  output logic [TsW-1:0] remainder_o
);

  logic [HW-1:0]   quo_q, quo_d;
  logic [TsW-1:0]  rem_q, rem_d;
  logic [TsW-1:0]  div_q;
  logic [CntW-1:0] cnt_q;
  logic            run_q;

  logic [TsW:0] trial;
  logic [TsW:0] diff;
  logic         ge;
  logic         last;
  logic         unused_diff_msb;

  always_comb begin
    trial = {rem_q, quo_q[HW-1]};
    diff  = trial - {1'b0, div_q};
    ge    = (trial >= {1'b0, div_q});
    rem_d = ge ? diff[TsW-1:0] : trial[TsW-1:0];
    quo_d = {quo_q[HW-2:0], ge};
    last  = (cnt_q == CntW'(DivSteps - 1));
  end

  assign unused_diff_msb = diff[TsW];

  assign done_o      = run_q && last;
  assign quotient_o  = quo_d;
  assign remainder_o = rem_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start_i) begin
      quo_q <= dividend_i;
      rem_q <= '0;
      div_q <= divisor_i;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      cnt_q <= cnt_q + 1'b1;
      if (last) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rp_chs_calc.sv
// Decodes an SD linear sector address into RP cylinder/track/sector using one shared divider.
// Optional range checking (odd LSA, zero geometry, cylinder overflow) enabled by RPCHS_RANGECHK_EN.
module rp_chs_calc
  import rp_chs_calc_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [TsW-1:0]  rpTRKNUM,
  input  logic [TsW-1:0]  rpSECNUM,
  input  logic [LsaW-1:0] rpSDLSA,
  input  logic            rpCHSSTRT,
  output logic            rpCHSBUSY,
  output logic [DcaW-1:0] rpDCA,
  output logic [TsW-1:0]  rpTA,
  output logic [TsW-1:0]  rpSA,
  output logic            rpCHSERR
);

  chs_state_e state_q, state_d;

  logic [HW-1:0]   lsa_hi_q;
  logic [TsW-1:0]  trk_q;
  logic [TsW-1:0]  sec_q;
  logic [TsW-1:0]  sa_tmp_q;
  logic [DcaW-1:0] dca_q;
  logic [TsW-1:0]  ta_q;
  logic [TsW-1:0]  sa_q;

  logic            div_start;
  logic [HW-1:0]   div_dividend;
  logic [TsW-1:0]  div_divisor;
  logic            div_done;
  logic [HW-1:0]   div_quo;
  logic [TsW-1:0]  div_rem;

  logic capture;
  logic sect_done;
  logic complete;
  logic geom_zero;

  rp_seqdiv u_div (
    .clk         (clk),
    .rst         (rst),
    .start_i     (div_start),
    .dividend_i  (div_dividend),
    .divisor_i   (div_divisor),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  // The sector quotient feeds straight back in as the track dividend on the SECT->TRACK edge.
  always_comb begin
    state_d      = state_q;
    div_start    = 1'b0;
    div_dividend = lsa_hi_q;
    div_divisor  = sec_q;
    capture      = 1'b0;
    sect_done    = 1'b0;
    complete     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rpCHSSTRT) begin
          capture = 1'b1;
          state_d = StLoad;
        end
      end
      StLoad: begin
        div_start = 1'b1;
        state_d   = StSect;
      end
      StSect: begin
        div_dividend = div_quo;
        div_divisor  = trk_q;
        if (div_done) begin
          div_start = 1'b1;
          sect_done = 1'b1;
          state_d   = StTrack;
        end
      end
      StTrack: begin
        if (div_done) begin
          complete = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign geom_zero = (sec_q == '0) || (trk_q == '0);
  assign rpCHSBUSY = (state_q != StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      lsa_hi_q <= '0;
      trk_q    <= '0;
      sec_q    <= '0;
      sa_tmp_q <= '0;
      dca_q    <= '0;
      ta_q     <= '0;
      sa_q     <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        lsa_hi_q <= rpSDLSA[LsaW-1:1];
        trk_q    <= rpTRKNUM;
        sec_q    <= rpSECNUM;
      end
      if (sect_done) begin
        sa_tmp_q <= div_rem;
      end
      if (complete) begin
        dca_q <= geom_zero ? '0 : div_quo[DcaW-1:0];
        ta_q  <= geom_zero ? '0 : div_rem;
        sa_q  <= geom_zero ? '0 : sa_tmp_q;
      end
    end
  end

  assign rpDCA = dca_q;
  assign rpTA  = ta_q;
  assign rpSA  = sa_q;

`ifdef RPCHS_RANGECHK_EN
  logic lsa_odd_q;
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lsa_odd_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (capture) begin
        lsa_odd_q <= rpSDLSA[0];
      end
      if (complete) begin
        err_q <= lsa_odd_q || geom_zero || (div_quo[HW-1:DcaW] != '0);
      end
    end
  end

  assign rpCHSERR = err_q;
`else
  logic unused_lsa0;
  logic unused_quo_hi;

  assign unused_lsa0   = rpSDLSA[0];
  assign unused_quo_hi = ^div_quo[HW-1:DcaW];
  assign rpCHSERR      = 1'b0;
`endif

endmodule

// File: tb/tb_rp_chs_calc.sv
// Directed self-checking bench for rp_chs_calc; expected error flag follows RPCHS_RANGECHK_EN.
module tb_rp_chs_calc;

`ifdef RPCHS_RANGECHK_EN
  localparam logic ErrOn = 1'b1;
`else
  localparam logic ErrOn = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [5:0]  trknum;
  logic [5:0]  secnum;
  logic [20:0] lsa;
  logic        strt;
  logic        busy;
  logic [9:0]  dca;
  logic [5:0]  ta;
  logic [5:0]  sa;
  logic        err;

  int n_cmp;
  int n_fail;
  int cyc;

  rp_chs_calc dut (
    .clk       (clk),
    .rst       (rst),
    .rpTRKNUM  (trknum),
    .rpSECNUM  (secnum),
    .rpSDLSA   (lsa),
    .rpCHSSTRT (strt),
    .rpCHSBUSY (busy),
    .rpDCA     (dca),
    .rpTA      (ta),
    .rpSA      (sa),
    .rpCHSERR  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input int e_dca, input int e_ta, input int e_sa,
                           input logic e_err);
    check({tag, ".dca"}, 32'(dca), 32'(e_dca));
    check({tag, ".ta"},  32'(ta),  32'(e_ta));
    check({tag, ".sa"},  32'(sa),  32'(e_sa));
    check({tag, ".err"}, 32'(err), 32'(e_err));
  endtask

  // Called just after a negedge; returns at the negedge where busy is first seen low.
  task automatic do_conv(input logic [5:0] t, input logic [5:0] s, input logic [20:0] a,
                         output int cycles);
    trknum = t;
    secnum = s;
    lsa    = a;
    strt   = 1'b1;
    @(posedge clk);
    #1 strt = 1'b0;
    cycles = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      cycles++;
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    strt   = 1'b0;
    trknum = '0;
    secnum = '0;
    lsa    = '0;
    #1;
    check("reset.busy", 32'(busy), 32'd0);
    check_out("reset", 0, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_conv(6'd19, 6'd20, 21'd3934, cyc);
    check("lsa3934.cycles", 32'(cyc), 32'd41);
    check_out("lsa3934", 5, 3, 7, 1'b0);

    do_conv(6'd19, 6'd20, 21'd778238, cyc);
    check("lsa778238.cycles", 32'(cyc), 32'd41);
    check_out("lsa778238", 1023, 18, 19, 1'b0);

    // Starts during busy and in the completion cycle must be ignored; inputs change mid-run.
    trknum = 6'd19;
    secnum = 6'd20;
    lsa    = 21'd3934;
    strt   = 1'b1;
    @(posedge clk);
    #1 strt = 1'b0;
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      cyc++;
      if (cyc == 10) begin
        strt   = 1'b1;
        lsa    = 21'd778238;
        trknum = 6'd1;
        secnum = 6'd1;
      end else if (cyc == 11) begin
        strt = 1'b0;
      end
      if (cyc == 20) check_out("ignore.hold", 1023, 18, 19, 1'b0);
      if (cyc == 41) strt = 1'b1;
    end
    strt = 1'b0;
    check("ignore.cycles", 32'(cyc), 32'd41);
    check_out("ignore", 5, 3, 7, 1'b0);
    repeat (2) @(negedge clk);
    check("ignore.idle", 32'(busy), 32'd0);
    check_out("ignore.keep", 5, 3, 7, 1'b0);

    // Reset 20 cycles into a conversion.
    trknum = 6'd19;
    secnum = 6'd20;
    lsa    = 21'd778238;
    strt   = 1'b1;
    @(posedge clk);
    #1 strt = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst.busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst.busy", 32'(busy), 32'd0);
    check_out("midrst", 0, 0, 0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_conv(6'd19, 6'd20, 21'd3934, cyc);
    check("postrst.cycles", 32'(cyc), 32'd41);
    check_out("postrst", 5, 3, 7, 1'b0);

    do_conv(6'd19, 6'd20, 21'd0, cyc);
    check_out("lsa0", 0, 0, 0, 1'b0);

    do_conv(6'd19, 6'd20, 21'd3935, cyc);
    check_out("lsa3935", 5, 3, 7, ErrOn);

    do_conv(6'd1, 6'd1, 21'd2048, cyc);
    check_out("ovf2048", 0, 0, 0, ErrOn);

    do_conv(6'd19, 6'd20, 21'd3934, cyc);
    check_out("clear", 5, 3, 7, 1'b0);

    do_conv(6'd19, 6'd0, 21'd3934, cyc);
    check("sec0.cycles", 32'(cyc), 32'd41);
    check_out("sec0", 0, 0, 0, ErrOn);

    do_conv(6'd0, 6'd20, 21'd3934, cyc);
    check_out("trk0", 0, 0, 0, ErrOn);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
